// File: rtl/mcpu_dram_arbiter_if.sv
// Request/acknowledge bundle between one DRAM master and the arbiter.
// The master drives a level-held request with private address, direction and write data.
interface mcpu_dram_arbiter_if #(
    parameter int unsigned DRAM_DATA_BITS = 16,
    parameter int unsigned DRAM_ADDR_BITS = 14
) ();
    logic                      req;
    logic                      we;
    logic [DRAM_ADDR_BITS-1:0] addr;
    logic [DRAM_DATA_BITS-1:0] wdata;
    logic [DRAM_DATA_BITS-1:0] rdata;
    logic                      ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );
endinterface

// File: rtl/mcpu_dram_arbiter.sv
// Two-port round-robin arbiter/sequencer for the shared MCPU DRAM.
// Each access takes IDLE -> ACCESS -> DONE; only one access is ever in flight.
module mcpu_dram_arbiter #(
    parameter int unsigned DRAM_DATA_BITS = 16,
    parameter int unsigned DRAM_ADDR_BITS = 14
) (
    input  logic                      clk,
    input  logic                      reset,
    mcpu_dram_arbiter_if.slave        m0,
    mcpu_dram_arbiter_if.slave        m1,
    output logic [DRAM_ADDR_BITS-1:0] dram_addr,
    inout  wire  [DRAM_DATA_BITS-1:0] data_bus,
    output logic                      dram_we,
    output logic                      dram_re
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic                      last_grant_q, last_grant_d;
    logic                      grant_q, grant_d;
    logic                      we_q, we_d;
    logic [DRAM_DATA_BITS-1:0] wdata_q, wdata_d;
    logic [DRAM_ADDR_BITS-1:0] dram_addr_q, dram_addr_d;
    logic                      dram_we_q, dram_we_d;
    logic                      dram_re_q, dram_re_d;
    logic                      m0_ack_q, m0_ack_d;
    logic                      m1_ack_q, m1_ack_d;
    logic [DRAM_DATA_BITS-1:0] m0_rdata_q, m0_rdata_d;
    logic [DRAM_DATA_BITS-1:0] m1_rdata_q, m1_rdata_d;
    logic                      sel;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant, latched request and registered output flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            dram_addr_q  <= '0;
            dram_we_q    <= 1'b0;
            dram_re_q    <= 1'b0;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            dram_addr_q  <= dram_addr_d;
            dram_we_q    <= dram_we_d;
            dram_re_q    <= dram_re_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    // Next-state and grant latching
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        dram_addr_d  = dram_addr_q;
        sel          = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (m0.req || m1.req) begin
                    // On contention the port that did not win last time goes first
                    sel          = (m0.req && m1.req) ? ~last_grant_q : m1.req;
                    grant_d      = sel;
                    last_grant_d = sel;
                    we_d         = sel ? m1.we    : m0.we;
                    wdata_d      = sel ? m1.wdata : m0.wdata;
                    dram_addr_d  = sel ? m1.addr  : m0.addr;
                    state_d      = StAccess;
                end
            end
            StAccess: state_d = StDone;
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Registered outputs are computed from the upcoming state so they line up with it
    always_comb begin
        dram_we_d  = (state_d == StAccess) && we_d;
        dram_re_d  = (state_d == StAccess) && !we_d;
        m0_ack_d   = (state_d == StDone) && !grant_q;
        m1_ack_d   = (state_d == StDone) && grant_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        if (state_q == StAccess && !we_q) begin
            if (grant_q) begin
                m1_rdata_d = data_bus;
            end else begin
                m0_rdata_d = data_bus;
            end
        end
    end

    // The bus is driven only while a write is presented to the DRAM
    assign data_bus  = dram_we_q ? wdata_q : {DRAM_DATA_BITS{1'bz}};
    assign dram_addr = dram_addr_q;
    assign dram_we   = dram_we_q;
    assign dram_re   = dram_re_q;
    assign m0.ack    = m0_ack_q;
    assign m1.ack    = m1_ack_q;
    assign m0.rdata  = m0_rdata_q;
    assign m1.rdata  = m1_rdata_q;

endmodule

// File: tb/tb_mcpu_dram_arbiter.sv
// Directed bench for mcpu_dram_arbiter with a behavioural DRAM on the shared bus.
module tb_mcpu_dram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [13:0] dram_addr;
    logic        dram_we;
    logic        dram_re;
    wire  [15:0] data_bus;

    int n_tests = 0;
    int n_fail  = 0;

    mcpu_dram_arbiter_if m0_if ();
    mcpu_dram_arbiter_if m1_if ();

    mcpu_dram_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .m0       (m0_if),
        .m1       (m1_if),
        .dram_addr(dram_addr),
        .data_bus (data_bus),
        .dram_we  (dram_we),
        .dram_re  (dram_re)
    );

    always #5 clk = ~clk;

    // Behavioural DRAM: writes on the rising edge, reads combinationally
    logic [15:0] mem [0:16383];
    always @(posedge clk) if (dram_we) mem[dram_addr] <= data_bus;
    assign data_bus = dram_re ? mem[dram_addr] : 16'hzzzz;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus hygiene, sampled every cycle away from the active edge
    always @(negedge clk) begin
        if (!reset) begin
            check("we_re_exclusive", {31'd0, dram_we & dram_re}, 32'd0);
            check("acks_exclusive", {31'd0, m0_if.ack & m1_if.ack}, 32'd0);
        end
    end

    typedef struct {
        bit          port;
        bit          we;
        logic [13:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_r0;
        logic [15:0] exp_r1;
    } vec_t;

    vec_t vecs [11];

    task automatic drive_port(input bit port, input bit req, input bit we,
                              input logic [13:0] addr, input logic [15:0] wdata);
        if (port) begin
            m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
        end else begin
            m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
        end
    endtask

    // One single-port access; returns ack cycle and what the DRAM side showed in ACCESS
    task automatic run_access(input bit port, input bit we, input logic [13:0] addr,
                              input logic [15:0] wdata, output int ack_cyc,
                              output bit other_ack, output logic [13:0] acc_addr,
                              output logic acc_we, output logic acc_re,
                              output logic [15:0] acc_bus);
        drive_port(port, 1'b1, we, addr, wdata);
        ack_cyc   = -1;
        other_ack = 1'b0;
        acc_addr  = '0;
        acc_we    = 1'b0;
        acc_re    = 1'b0;
        acc_bus   = '0;
        for (int c = 1; c <= 6 && ack_cyc < 0; c++) begin
            @(negedge clk);
            if (c == 1) begin
                acc_addr = dram_addr; acc_we = dram_we; acc_re = dram_re; acc_bus = data_bus;
            end
            if ((port ? m1_if.ack : m0_if.ack) == 1'b1) ack_cyc = c;
            if ((port ? m0_if.ack : m1_if.ack) == 1'b1) other_ack = 1'b1;
        end
        drive_port(port, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
    endtask

    initial begin
        int          ack_cyc;
        bit          other_ack;
        logic [13:0] acc_addr;
        logic        acc_we, acc_re;
        logic [15:0] acc_bus;
        int          c0, c1;
        logic [13:0] a1, a4;
        logic [15:0] b1, b4;
        logic        w1, w4;

        vecs[0]  = '{1'b0, 1'b1, 14'h0123, 16'hBEEF, 16'h0000, 16'h0000};
        vecs[1]  = '{1'b0, 1'b0, 14'h0123, 16'h0000, 16'hBEEF, 16'h0000};
        vecs[2]  = '{1'b0, 1'b0, 14'h0010, 16'h0000, 16'h1111, 16'h0000};
        vecs[3]  = '{1'b1, 1'b0, 14'h0020, 16'h0000, 16'h1111, 16'h2222};
        vecs[4]  = '{1'b0, 1'b1, 14'h0005, 16'h1234, 16'h1111, 16'h2222};
        vecs[5]  = '{1'b1, 1'b1, 14'h0040, 16'h5555, 16'h1111, 16'h2222};
        vecs[6]  = '{1'b0, 1'b1, 14'h0041, 16'hAAAA, 16'h1111, 16'h2222};
        vecs[7]  = '{1'b0, 1'b0, 14'h0041, 16'h0000, 16'hAAAA, 16'h2222};
        vecs[8]  = '{1'b1, 1'b0, 14'h0040, 16'h0000, 16'hAAAA, 16'h5555};
        vecs[9]  = '{1'b0, 1'b1, 14'h0042, 16'h0F0F, 16'hAAAA, 16'h5555};
        vecs[10] = '{1'b0, 1'b0, 14'h0042, 16'h0000, 16'h0F0F, 16'h5555};

        reset = 1'b1;
        drive_port(1'b0, 1'b0, 1'b0, '0, '0);
        drive_port(1'b1, 1'b0, 1'b0, '0, '0);
        repeat (2) @(negedge clk);
        check("rst_dram_we", {31'd0, dram_we}, 32'd0);
        check("rst_dram_re", {31'd0, dram_re}, 32'd0);
        check("rst_dram_addr", {18'd0, dram_addr}, 32'd0);
        check("rst_acks", {30'd0, m0_if.ack, m1_if.ack}, 32'd0);
        check("rst_rdata", {m0_if.rdata, m1_if.rdata}, 32'd0);
        reset = 1'b0;

        // Simultaneous requests straight out of reset: port 0 wins first
        drive_port(1'b0, 1'b1, 1'b1, 14'h0010, 16'h1111);
        drive_port(1'b1, 1'b1, 1'b1, 14'h0020, 16'h2222);
        c0 = -1; c1 = -1;
        a1 = '0; a4 = '0; b1 = '0; b4 = '0; w1 = 1'b0; w4 = 1'b0;
        for (int c = 1; c <= 10 && (c0 < 0 || c1 < 0); c++) begin
            @(negedge clk);
            if (c == 1) begin a1 = dram_addr; b1 = data_bus; w1 = dram_we; end
            if (c == 4) begin a4 = dram_addr; b4 = data_bus; w4 = dram_we; end
            if (m0_if.ack) begin c0 = c; m0_if.req = 1'b0; end
            if (m1_if.ack) begin c1 = c; m1_if.req = 1'b0; end
        end
        @(negedge clk);
        check("sim_m0_ack_cycle", c0, 2);
        check("sim_m1_ack_cycle", c1, 5);
        check("sim_first_addr", {18'd0, a1}, 32'h10);
        check("sim_first_bus", {16'd0, b1}, 32'h1111);
        check("sim_first_we", {31'd0, w1}, 32'd1);
        check("sim_second_addr", {18'd0, a4}, 32'h20);
        check("sim_second_bus", {16'd0, b4}, 32'h2222);
        check("sim_second_we", {31'd0, w4}, 32'd1);

        // Table of single-port accesses
        for (int i = 0; i < 11; i++) begin
            run_access(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, ack_cyc,
                       other_ack, acc_addr, acc_we, acc_re, acc_bus);
            check($sformatf("v%0d_ack_cycle", i), ack_cyc, 2);
            check($sformatf("v%0d_other_ack", i), {31'd0, other_ack}, 32'd0);
            check($sformatf("v%0d_dram_addr", i), {18'd0, acc_addr}, {18'd0, vecs[i].addr});
            check($sformatf("v%0d_dram_we", i), {31'd0, acc_we}, {31'd0, vecs[i].we});
            check($sformatf("v%0d_dram_re", i), {31'd0, acc_re}, {31'd0, !vecs[i].we});
            if (vecs[i].we)
                check($sformatf("v%0d_wr_bus", i), {16'd0, acc_bus}, {16'd0, vecs[i].wdata});
            check($sformatf("v%0d_m0_rdata", i), {16'd0, m0_if.rdata}, {16'd0, vecs[i].exp_r0});
            check($sformatf("v%0d_m1_rdata", i), {16'd0, m1_if.rdata}, {16'd0, vecs[i].exp_r1});
        end

        // Sustained contention: both ports hold req high; last grant was port 0
        begin
            logic [15:0] exp0, exp1;
            int          n_acks, last_c, exp_port;
            exp0 = 16'h0F0F; exp1 = 16'h5555;
            n_acks = 0; last_c = 0; exp_port = 1;
            drive_port(1'b0, 1'b1, 1'b0, 14'h0123, '0);
            drive_port(1'b1, 1'b1, 1'b0, 14'h0020, '0);
            for (int c = 1; c <= 40 && n_acks < 8; c++) begin
                @(negedge clk);
                if (m0_if.ack || m1_if.ack) begin
                    check($sformatf("rr_grant%0d", n_acks), {31'd0, m1_if.ack}, exp_port);
                    if (n_acks > 0) check($sformatf("rr_gap%0d", n_acks), c - last_c, 3);
                    if (exp_port == 1) exp1 = 16'h2222; else exp0 = 16'hBEEF;
                    check($sformatf("rr_m0_rdata%0d", n_acks), {16'd0, m0_if.rdata}, {16'd0, exp0});
                    check($sformatf("rr_m1_rdata%0d", n_acks), {16'd0, m1_if.rdata}, {16'd0, exp1});
                    last_c = c;
                    exp_port = 1 - exp_port;
                    n_acks++;
                end
            end
            drive_port(1'b0, 1'b0, 1'b0, '0, '0);
            drive_port(1'b1, 1'b0, 1'b0, '0, '0);
            check("rr_ack_count", n_acks, 8);
            repeat (2) @(negedge clk);
        end

        // Reset during ACCESS of an m1 write must not commit it
        begin
            bit late_ack;
            drive_port(1'b1, 1'b1, 1'b1, 14'h0005, 16'hDEAD);
            @(negedge clk);
            check("mid_pre_we", {31'd0, dram_we}, 32'd1);
            #2 reset = 1'b1;
            #1;
            check("mid_dram_we", {31'd0, dram_we}, 32'd0);
            check("mid_dram_re", {31'd0, dram_re}, 32'd0);
            check("mid_dram_addr", {18'd0, dram_addr}, 32'd0);
            check("mid_rdata", {m0_if.rdata, m1_if.rdata}, 32'd0);
            drive_port(1'b1, 1'b0, 1'b0, '0, '0);
            late_ack = 1'b0;
            @(negedge clk);
            if (m1_if.ack) late_ack = 1'b1;
            reset = 1'b0;
            repeat (4) begin
                @(negedge clk);
                if (m1_if.ack || m0_if.ack) late_ack = 1'b1;
            end
            check("mid_no_ack", {31'd0, late_ack}, 32'd0);
            run_access(1'b1, 1'b0, 14'h0005, '0, ack_cyc, other_ack, acc_addr, acc_we, acc_re,
                       acc_bus);
            check("mid_read_ack", ack_cyc, 2);
            check("mid_read_val", {16'd0, m1_if.rdata}, 32'h1234);
            check("mid_m0_rdata", {16'd0, m0_if.rdata}, 32'h0000);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
